// File: rtl/core_pkg.sv
// Shared core definitions: writeback selects, funct3 codes
// and the memory-stage FSM encoding.
package core_pkg;

  localparam logic [3:0] WB_ALU = 4'd0;
  localparam logic [3:0] WB_MEM = 4'd1;
  localparam logic [3:0] WB_PC  = 4'd2;
  localparam logic [3:0] WB_CSR = 4'd3;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port between the memory stage (master)
// and the data memory (slave).
interface mem_stage_if #(
  parameter int XLEN = 32
);

  logic [XLEN-1:0] memory_d_addr;
  logic            memory_d_ren;
  logic            memory_wen;
  logic [XLEN-1:0] memory_wmask;
  logic [XLEN-1:0] memory_wdata;
  logic [XLEN-1:0] memory_rdata;
  logic            memory_ready;

  modport master (
    output memory_d_addr,
    output memory_d_ren,
    output memory_wen,
    output memory_wmask,
    output memory_wdata,
    input  memory_rdata,
    input  memory_ready
  );

  modport slave (
    input  memory_d_addr,
    input  memory_d_ren,
    input  memory_wen,
    input  memory_wmask,
    input  memory_wdata,
    output memory_rdata,
    output memory_ready
  );

endinterface

// File: rtl/mem_align.sv
// Combinational store lane/mask generation, load lane
// extraction/extension and access legality check.
module mem_align
  import core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      lane_i,
  input  logic            is_store_i,
  input  logic [XLEN-1:0] st_data_i,
  input  logic [XLEN-1:0] ld_word_i,
  output logic [XLEN-1:0] wmask_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] ld_data_o,
  output logic            misaligned_o
);

  logic [XLEN-1:0] shifted;

  assign shifted = ld_word_i >> {lane_i, 3'b000};

  always_comb begin
    wmask_o      = '0;
    wdata_o      = '0;
    ld_data_o    = '0;
    misaligned_o = 1'b1;
    case (funct3_i)
      F3_B: begin
        misaligned_o = 1'b0;
        wmask_o   = XLEN'(8'hFF) << {lane_i, 3'b000};
        wdata_o   = {(XLEN/8){st_data_i[7:0]}};
        ld_data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      end
      F3_BU: begin
        // zero-extending forms exist only for loads
        misaligned_o = is_store_i;
        ld_data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
      end
      F3_H: begin
        misaligned_o = lane_i[0];
        wmask_o   = XLEN'(16'hFFFF) << {lane_i[1], 4'b0000};
        wdata_o   = {(XLEN/16){st_data_i[15:0]}};
        ld_data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      end
      F3_HU: begin
        misaligned_o = is_store_i | lane_i[0];
        ld_data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
      end
      F3_W: begin
        misaligned_o = (lane_i != 2'b00);
        wmask_o   = '1;
        wdata_o   = st_data_i;
        ld_data_o = ld_word_i;
      end
      default: begin
        misaligned_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: issues loads/stores on the
// data port, stalls upstream, emits a writeback packet.
module mem_stage
  import core_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_alu_out,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic            in_mem_wen,
  input  logic [2:0]      in_funct3,
  input  logic [3:0]      in_wb_sel,
  input  logic [4:0]      in_wb_addr,
  input  logic            in_rf_wen,
  input  logic [XLEN-1:0] in_pc,
  mem_stage_if.master     dmem,
  output logic            out_valid,
  output logic [XLEN-1:0] out_wb_data,
  output logic [4:0]      out_wb_addr,
  output logic            out_rf_wen,
  output logic [XLEN-1:0] out_pc,
  output logic            out_err
);

  localparam int CW =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST =
    CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  mem_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [2:0]      f3_q, f3_d;
  logic [4:0]      wba_q, wba_d;
  logic            rfw_q, rfw_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            ov_q, ov_d;
  logic [XLEN-1:0] owd_q, owd_d;
  logic [4:0]      owa_q, owa_d;
  logic            orw_q, orw_d;
  logic [XLEN-1:0] opc_q, opc_d;
  logic            oerr_q, oerr_d;

  logic [XLEN-1:0] da_q, da_d;
  logic            ren_q, ren_d;
  logic            wen_q, wen_d;
  logic [XLEN-1:0] wm_q, wm_d;
  logic [XLEN-1:0] wd_q, wd_d;

  logic            idle, is_store, is_mem;
  logic            timeout, done_ok;
  logic [2:0]      al_f3;
  logic [1:0]      al_lane;
  logic [XLEN-1:0] al_wmask, al_wdata, al_ld;
  logic            al_mis;

  assign idle     = (state_q == IDLE);
  assign is_store = in_mem_wen;
  assign is_mem   = in_mem_wen | (in_wb_sel == WB_MEM);
  assign timeout  = (MEM_TIMEOUT > 0) && (cnt_q == TO_LAST);
  assign done_ok  = dmem.memory_ready;

  // IDLE decodes the incoming op; wait states decode the held one
  assign al_f3   = idle ? in_funct3 : f3_q;
  assign al_lane = idle ? in_alu_out[1:0] : addr_q[1:0];

  mem_align #(.XLEN(XLEN)) u_align (
    .funct3_i     (al_f3),
    .lane_i       (al_lane),
    .is_store_i   (is_store),
    .st_data_i    (in_rs2_data),
    .ld_word_i    (dmem.memory_rdata),
    .wmask_o      (al_wmask),
    .wdata_o      (al_wdata),
    .ld_data_o    (al_ld),
    .misaligned_o (al_mis)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    wba_d   = wba_q;
    rfw_d   = rfw_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ov_d    = 1'b0;
    owd_d   = owd_q;
    owa_d   = owa_q;
    orw_d   = orw_q;
    opc_d   = opc_q;
    oerr_d  = oerr_q;
    da_d    = da_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    wm_d    = wm_q;
    wd_d    = wd_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          addr_d = in_alu_out;
          f3_d   = in_funct3;
          wba_d  = in_wb_addr;
          rfw_d  = in_rf_wen;
          pc_d   = in_pc;
          cnt_d  = '0;
          if (is_mem && !al_mis) begin
            da_d = {in_alu_out[XLEN-1:2], 2'b00};
            if (is_store) begin
              wen_d   = 1'b1;
              wm_d    = al_wmask;
              wd_d    = al_wdata;
              state_d = WR_WAIT;
            end else begin
              ren_d   = 1'b1;
              state_d = RD_WAIT;
            end
          end else begin
            ov_d   = 1'b1;
            owd_d  = in_alu_out;
            owa_d  = in_wb_addr;
            opc_d  = in_pc;
            oerr_d = is_mem;
            orw_d  = in_rf_wen & ~is_mem;
          end
        end
      end
      RD_WAIT, WR_WAIT: begin
        // a ready response wins over a coincident timeout
        if (done_ok || timeout) begin
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          wm_d    = '0;
          state_d = IDLE;
          ov_d    = 1'b1;
          owa_d   = wba_q;
          opc_d   = pc_q;
          oerr_d  = ~done_ok;
          orw_d   = done_ok & rfw_q &
                    (state_q == RD_WAIT);
          owd_d   = (done_ok && state_q == RD_WAIT) ?
                    al_ld : addr_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      wba_q   <= '0;
      rfw_q   <= 1'b0;
      pc_q    <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      owd_q   <= '0;
      owa_q   <= '0;
      orw_q   <= 1'b0;
      opc_q   <= '0;
      oerr_q  <= 1'b0;
      da_q    <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      wm_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      wba_q   <= wba_d;
      rfw_q   <= rfw_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ov_q    <= ov_d;
      owd_q   <= owd_d;
      owa_q   <= owa_d;
      orw_q   <= orw_d;
      opc_q   <= opc_d;
      oerr_q  <= oerr_d;
      da_q    <= da_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      wm_q    <= wm_d;
      wd_q    <= wd_d;
    end
  end

  assign in_ready           = idle;
  assign out_valid          = ov_q;
  assign out_wb_data        = owd_q;
  assign out_wb_addr        = owa_q;
  assign out_rf_wen         = orw_q;
  assign out_pc             = opc_q;
  assign out_err            = oerr_q;
  assign dmem.memory_d_addr = da_q;
  assign dmem.memory_d_ren  = ren_q;
  assign dmem.memory_wen    = wen_q;
  assign dmem.memory_wmask  = wm_q;
  assign dmem.memory_wdata  = wd_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized checks of mem_stage against a
// byte-level behavioural model of RV32I loads/stores.
module tb_mem_stage;
  import core_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_alu_out, in_rs2_data, in_pc;
  logic        in_mem_wen, in_rf_wen;
  logic [2:0]  in_funct3;
  logic [3:0]  in_wb_sel;
  logic [4:0]  in_wb_addr;
  logic        out_valid, out_rf_wen, out_err;
  logic [31:0] out_wb_data, out_pc;
  logic [4:0]  out_wb_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage_if #(.XLEN(32)) mif ();

  mem_stage #(.XLEN(32), .MEM_TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_alu_out  (in_alu_out),
    .in_rs2_data (in_rs2_data),
    .in_mem_wen  (in_mem_wen),
    .in_funct3   (in_funct3),
    .in_wb_sel   (in_wb_sel),
    .in_wb_addr  (in_wb_addr),
    .in_rf_wen   (in_rf_wen),
    .in_pc       (in_pc),
    .dmem        (mif),
    .out_valid   (out_valid),
    .out_wb_data (out_wb_data),
    .out_wb_addr (out_wb_addr),
    .out_rf_wen  (out_rf_wen),
    .out_pc      (out_pc),
    .out_err     (out_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [2:0] f3,
                       input logic st,
                       input logic [3:0] sel,
                       input logic [4:0] wa,
                       input logic rw,
                       input logic [31:0] pc);
    in_alu_out  = a;
    in_rs2_data = d;
    in_funct3   = f3;
    in_mem_wen  = st;
    in_wb_sel   = sel;
    in_wb_addr  = wa;
    in_rf_wen   = rw;
    in_pc       = pc;
    in_valid    = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    in_valid = 1'b0;
    issue(0, 0, 0, 0, WB_ALU, 0, 0, 0);
    in_valid = 1'b0;
    mif.memory_ready = 1'b0;
    mif.memory_rdata = '0;
    tick;
    tick;
    reset = 1'b0;
    total++;
    if ({out_valid, out_err, out_rf_wen} !== 3'b000) begin
      bad++;
      $display("FAIL rst_flags got=%b exp=000",
               {out_valid, out_err, out_rf_wen});
    end
    total++;
    if ({mif.memory_d_ren, mif.memory_wen, in_ready}
        !== 3'b001) begin
      bad++;
      $display("FAIL rst_req got=%b exp=001",
        {mif.memory_d_ren, mif.memory_wen, in_ready});
    end
    total++;
    if ({mif.memory_wmask, mif.memory_d_addr,
         mif.memory_wdata, out_wb_data, out_pc,
         out_wb_addr} !== '0) begin
      bad++;
      $display("FAIL rst_data got=%h/%h/%h exp=0",
        mif.memory_wmask, mif.memory_d_addr, out_wb_data);
    end
  endtask

  task automatic test_alu;
    mif.memory_ready = 1'b1;
    issue(32'h1234, 0, 0, 0, WB_ALU, 5, 1, 32'h40);
    tick;
    total++;
    if ({out_valid, out_rf_wen, out_err, out_wb_addr}
        !== {3'b110, 5'd5}) begin
      bad++;
      $display("FAIL alu_ctl got=%b exp=11000101",
        {out_valid, out_rf_wen, out_err, out_wb_addr});
    end
    total++;
    if (out_wb_data !== 32'h1234 || out_pc !== 32'h40) begin
      bad++;
      $display("FAIL alu_data got=%h/%h exp=1234/40",
               out_wb_data, out_pc);
    end
    total++;
    if (in_ready !== 1'b1 || mif.memory_d_ren !== 1'b0) begin
      bad++;
      $display("FAIL alu_ready got=%b%b exp=10",
               in_ready, mif.memory_d_ren);
    end
    issue(32'h5678, 0, 0, 0, WB_PC, 7, 1, 32'h44);
    tick;
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_wb_data !== 32'h5678 ||
        out_wb_addr !== 5'd7) begin
      bad++;
      $display("FAIL alu_b2b got=%b/%h/%0d exp=1/5678/7",
               out_valid, out_wb_data, out_wb_addr);
    end
    tick;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL alu_pulse got=%b exp=0", out_valid);
    end
    mif.memory_ready = 1'b0;
  endtask

  task automatic test_lb;
    issue(32'h103, 0, F3_B, 0, WB_MEM, 3, 1, 32'h80);
    tick;
    in_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      total++;
      if ({mif.memory_d_ren, in_ready, out_valid} !== 3'b100 ||
          mif.memory_d_addr !== 32'h100) begin
        bad++;
        $display("FAIL lb_wait%0d got=%b/%h exp=100/100", k,
          {mif.memory_d_ren, in_ready, out_valid},
          mif.memory_d_addr);
      end
      if (k == 3) begin
        mif.memory_ready = 1'b1;
        mif.memory_rdata = 32'h80FF_0011;
      end
      tick;
      mif.memory_ready = 1'b0;
    end
    total++;
    if (out_valid !== 1'b1 || out_wb_data !== 32'hFFFF_FF80 ||
        out_rf_wen !== 1'b1 || mif.memory_d_ren !== 1'b0) begin
      bad++;
      $display("FAIL lb_result got=%b/%h/%b/%b exp=1/ffffff80/1/0",
        out_valid, out_wb_data, out_rf_wen, mif.memory_d_ren);
    end
  endtask

  task automatic test_sh_lhu;
    issue(32'h202, 32'hDEAD_BEEF, F3_H, 1, WB_ALU, 0, 0, 4);
    tick;
    in_valid = 1'b0;
    total++;
    if (mif.memory_wen !== 1'b1 ||
        mif.memory_wmask !== 32'hFFFF_0000 ||
        mif.memory_wdata[31:16] !== 16'hBEEF ||
        mif.memory_d_addr !== 32'h200) begin
      bad++;
      $display("FAIL sh_req got=%b/%h/%h/%h exp=1/ffff0000/beef/200",
        mif.memory_wen, mif.memory_wmask,
        mif.memory_wdata[31:16], mif.memory_d_addr);
    end
    mif.memory_ready = 1'b1;
    tick;
    mif.memory_ready = 1'b0;
    total++;
    if ({out_valid, out_rf_wen, out_err, mif.memory_wen}
        !== 4'b1000 || mif.memory_wmask !== '0) begin
      bad++;
      $display("FAIL sh_done got=%b/%h exp=1000/0",
        {out_valid, out_rf_wen, out_err, mif.memory_wen},
        mif.memory_wmask);
    end
    issue(32'h202, 0, F3_HU, 0, WB_MEM, 9, 1, 8);
    tick;
    in_valid = 1'b0;
    mif.memory_ready = 1'b1;
    mif.memory_rdata = 32'hBEEF_0000;
    tick;
    mif.memory_ready = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_wb_data !== 32'h0000_BEEF) begin
      bad++;
      $display("FAIL lhu_result got=%b/%h exp=1/0000beef",
               out_valid, out_wb_data);
    end
  endtask

  task automatic test_misaligned;
    issue(32'h101, 0, F3_W, 0, WB_MEM, 4, 1, 12);
    tick;
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_err, out_rf_wen, in_ready,
         mif.memory_d_ren, mif.memory_wen} !== 6'b110100) begin
      bad++;
      $display("FAIL misalign got=%b exp=110100",
        {out_valid, out_err, out_rf_wen, in_ready,
         mif.memory_d_ren, mif.memory_wen});
    end
  endtask

  task automatic test_reset_mid;
    issue(32'h40, 0, F3_W, 0, WB_MEM, 2, 1, 16);
    tick;
    in_valid = 1'b0;
    total++;
    if (mif.memory_d_ren !== 1'b1) begin
      bad++;
      $display("FAIL rmid_ren got=%b exp=1", mif.memory_d_ren);
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    total++;
    if ({mif.memory_d_ren, in_ready, out_valid} !== 3'b010) begin
      bad++;
      $display("FAIL rmid_state got=%b exp=010",
               {mif.memory_d_ren, in_ready, out_valid});
    end
    tick;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rmid_novalid got=%b exp=0", out_valid);
    end
    issue(32'h0, 0, F3_W, 0, WB_MEM, 1, 1, 20);
    tick;
    in_valid = 1'b0;
    mif.memory_ready = 1'b1;
    mif.memory_rdata = 32'h0000_0013;
    tick;
    mif.memory_ready = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_wb_data !== 32'h13) begin
      bad++;
      $display("FAIL rmid_lw got=%b/%h exp=1/13",
               out_valid, out_wb_data);
    end
  endtask

  task automatic test_timeout;
    issue(32'h10, 0, F3_W, 0, WB_MEM, 6, 1, 24);
    tick;
    in_valid = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      total++;
      if (mif.memory_d_ren !== 1'b1 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL to_wait%0d got=%b%b exp=10", k,
                 mif.memory_d_ren, out_valid);
      end
      tick;
    end
    total++;
    if ({mif.memory_d_ren, out_valid, out_err, out_rf_wen,
         in_ready} !== 5'b01101) begin
      bad++;
      $display("FAIL to_done got=%b exp=01101",
        {mif.memory_d_ren, out_valid, out_err, out_rf_wen,
         in_ready});
    end
  endtask

  task automatic test_random;
    logic [2:0]  f3s [5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
    logic [3:0]  sels [3] = '{WB_ALU, WB_PC, WB_CSR};
    for (int n = 0; n < 300; n++) begin
      int          kind, size, off, delay;
      logic [31:0] a, d, rd, pc, mask, w, exp_d;
      logic [2:0]  f3;
      logic [3:0]  sel;
      logic [4:0]  wa;
      logic        rw, st, mem, legal, err, done;
      kind = $urandom_range(0, 2);
      a    = $urandom;
      d    = $urandom;
      rd   = $urandom;
      pc   = $urandom;
      wa   = 5'($urandom);
      rw   = 1'($urandom);
      f3   = ($urandom_range(0, 9) < 8) ?
             f3s[$urandom_range(0, 4)] : 3'($urandom);
      st   = (kind == 2);
      sel  = (kind == 1) ? WB_MEM : sels[$urandom_range(0, 2)];
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      if ($urandom_range(0, 1) == 1) a = a & ~32'(size - 1);
      off   = int'(a % 4);
      mem   = st || (sel == WB_MEM);
      legal = st ? (f3 == 0 || f3 == 1 || f3 == 2)
                 : (f3 == 0 || f3 == 1 || f3 == 2 ||
                    f3 == 4 || f3 == 5);
      err   = mem && !(legal && (a % size == 0));
      delay = $urandom_range(1, TO + 2);
      issue(a, d, f3, st, sel, wa, rw, pc);
      tick;
      in_valid = 1'b0;
      if (!mem || err) begin
        total++;
        if ({out_valid, out_err, out_rf_wen, out_wb_addr,
             mif.memory_d_ren, mif.memory_wen, in_ready} !==
            {1'b1, err, rw && !mem, wa, 3'b001} ||
            out_pc !== pc ||
            (!mem && out_wb_data !== a)) begin
          bad++;
          $display("FAIL rnd%0d_imm got=%b/%h exp=%b/%h", n,
            {out_valid, out_err, out_rf_wen, out_wb_addr,
             mif.memory_d_ren, mif.memory_wen, in_ready},
            out_wb_data,
            {1'b1, err, rw && !mem, wa, 3'b001}, a);
        end
        continue;
      end
      mask = '0;
      for (int b = 0; b < size; b++)
        mask = mask | (32'hFF << (8 * (off + b)));
      total++;
      if (mif.memory_d_addr !== (a & ~32'd3) ||
          {mif.memory_d_ren, mif.memory_wen} !== {!st, st} ||
          (st && mif.memory_wmask !== mask) ||
          (st && (mif.memory_wdata & mask) !==
                 ((d << (8 * off)) & mask))) begin
        bad++;
        $display("FAIL rnd%0d_req got=%h/%b%b/%h/%h exp=%h/%b%b/%h",
          n, mif.memory_d_addr, mif.memory_d_ren,
          mif.memory_wen, mif.memory_wmask, mif.memory_wdata,
          a & ~32'd3, !st, st, mask);
      end
      for (int k = 1; k <= TO; k++) begin
        total++;
        if ({mif.memory_d_ren, mif.memory_wen, out_valid,
             in_ready} !== {!st, st, 2'b00}) begin
          bad++;
          $display("FAIL rnd%0d_hold%0d got=%b exp=%b", n, k,
            {mif.memory_d_ren, mif.memory_wen, out_valid,
             in_ready}, {!st, st, 2'b00});
        end
        mif.memory_ready = (k == delay);
        mif.memory_rdata = (k == delay) ? rd : 32'($urandom);
        tick;
        mif.memory_ready = 1'b0;
        if (k == delay) break;
      end
      done = (delay <= TO);
      w = rd >> (8 * off);
      case (f3)
        F3_B:    exp_d = 32'($signed(w[7:0]));
        F3_H:    exp_d = 32'($signed(w[15:0]));
        F3_BU:   exp_d = 32'(w[7:0]);
        F3_HU:   exp_d = 32'(w[15:0]);
        default: exp_d = rd;
      endcase
      total++;
      if ({out_valid, out_err, out_rf_wen, out_wb_addr,
           mif.memory_d_ren, mif.memory_wen} !==
          {1'b1, !done, done && !st && rw, wa, 2'b00} ||
          mif.memory_wmask !== '0 || out_pc !== pc ||
          (done && !st && out_wb_data !== exp_d)) begin
        bad++;
        $display("FAIL rnd%0d_done got=%b/%h exp=%b/%h", n,
          {out_valid, out_err, out_rf_wen, out_wb_addr,
           mif.memory_d_ren, mif.memory_wen}, out_wb_data,
          {1'b1, !done, done && !st && rw, wa, 2'b00}, exp_d);
      end
    end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_lb;
    test_sh_lhu;
    test_misaligned;
    test_reset_mid;
    test_timeout;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage in the pipelined core.
- Takes the execute result (ALU address/value, store data, writeback control) and performs RV32I loads and stores on the data memory port: LB/LH/LW/LBU/LHU/SB/SH/SW.
- Stalls the upstream stages while memory is busy.
- Hands a registered writeback packet to the writeback stage.

Parameters:
- XLEN, 32, datapath width.
- MEM_TIMEOUT, 0, cycles to wait for memory_ready before raising out_err. 0 means wait forever.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  execute result valid
- in_ready  out  1  stage can accept an input this cycle
- in_alu_out  in  32  ALU result; the byte address for loads and stores
- in_rs2_data  in  32  store data
- in_mem_wen  in  1  instruction is a store
- in_funct3  in  3  access size/sign (RISC-V funct3)
- in_wb_sel  in  4  writeback source select
- in_wb_addr  in  5  destination register
- in_rf_wen  in  1  register write enable
- in_pc  in  32  instruction PC (for debug/exception)
- memory_d_addr  out  32  word-aligned data address
- memory_d_ren  out  1  read request
- memory_wen  out  1  write request
- memory_wmask  out  32  bitwise write mask
- memory_wdata  out  32  lane-shifted store data
- memory_rdata  in  32  read word
- memory_ready  in  1  access completes this cycle
- out_valid  out  1  writeback packet valid (one-cycle pulse per instruction)
- out_wb_data  out  32  ALU result, or extended load data
- out_wb_addr  out  5  destination register
- out_rf_wen  out  1  register write enable
- out_pc  out  32  instruction PC
- out_err  out  1  misaligned access or timeout; qualified by out_valid

Behaviour:
- Reset is synchronous, active-high. Reset values:
  - state=IDLE.
  - out_valid, out_rf_wen, out_err, memory_d_ren, memory_wen = 0.
  - memory_wmask = 0.
  - out_wb_data, out_wb_addr, out_pc, memory_d_addr, memory_wdata = 0.
- Reset asserted mid-access: the FSM returns to IDLE at that edge and the request lines drop. The pending instruction is discarded and no out_valid is produced.
- in_ready = (state==IDLE). An input is accepted on a clk edge when in_valid && in_ready.
- FSM states: IDLE, RD_WAIT, WR_WAIT.
- IDLE, accepted op with in_wb_sel!=WB_MEM and in_mem_wen=0:
  - Next cycle: out_valid=1, out_wb_data=in_alu_out, other fields passed through.
  - Latency 1 cycle. Stays in IDLE, so back-to-back issue is possible.
- IDLE, accepted load (wb_sel==WB_MEM):
  - Register memory_d_addr = {addr[31:2],2'b00}, assert memory_d_ren, go to RD_WAIT.
- IDLE, accepted store (mem_wen=1):
  - Register the address, assert memory_wen.
  - wmask: byte = 0xFF << 8*addr[1:0]; half = 0xFFFF << 16*addr[1]; word = all ones.
  - wdata = rs2_data replicated into the addressed lane.
  - Go to WR_WAIT.
- Request outputs hold stable until memory_ready is sampled high.
- RD_WAIT with memory_ready=1:
  - Select the lane by addr[1:0].
  - funct3 000 sign-extends a byte, 100 zero-extends a byte, 001 sign-extends a half, 101 zero-extends a half, 010 takes the full word.
  - Register the result into out_wb_data, pulse out_valid, drop memory_d_ren, return to IDLE.
  - Minimum load latency is 2 cycles from accept to out_valid.
- WR_WAIT with memory_ready=1:
  - Drop memory_wen and clear wmask, pulse out_valid with out_rf_wen=0, return to IDLE.
- memory_ready outside a wait state is ignored.
- Misalignment: a half access with addr[0]=1, or a word access with addr[1:0]!=0.
  - No memory request is made.
  - Next cycle: out_valid=1, out_err=1, out_rf_wen=0. Stays in IDLE.
- Timeout (MEM_TIMEOUT>0): a counter in a wait state reaching MEM_TIMEOUT drops the request, pulses out_valid with out_err=1 and out_rf_wen=0, and returns to IDLE.
- An undefined funct3 on a memory op is treated as misaligned (out_err=1).

Decomposition:
- Shared package core_pkg:
  - WB_ALU=4'd0, WB_MEM=4'd1, WB_PC=4'd2, WB_CSR=4'd3.
  - funct3 constants F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
  - FSM state encoding.
- One sub-module, mem_align: combinational store lane/mask generation and load extraction/extension, reused by a future cache.

Test Plan:
- ALU passthrough: in_alu_out=0x1234, wb_sel=WB_ALU, rf_wen=1, wb_addr=5 -> next cycle out_valid=1, out_wb_data=0x1234, out_wb_addr=5. in_ready stays 1.
- LB sign-extend:
  - Stimulus: addr=0x103, funct3=000, memory_ready high 3 cycles later with rdata=0x80FF_0011.
  - Response: memory_d_addr=0x100 and ren held 3 cycles; out_wb_data=0xFFFF_FF80. in_ready=0 throughout the wait.
- SH:
  - Stimulus: addr=0x202, rs2=0xDEAD_BEEF, memory_ready immediate.
  - Response: memory_wmask=0xFFFF_0000, memory_wdata=0xBEEF_xxxx (upper half 0xBEEF), then out_valid with out_rf_wen=0. LHU of 0x202 afterwards with rdata=0xBEEF_0000 returns 0x0000_BEEF.
- Misaligned LW at addr=0x101 -> no ren/wen ever asserted; next cycle out_valid=1, out_err=1, out_rf_wen=0.
- Reset mid-access: assert reset in RD_WAIT -> next edge ren=0, in_ready=1, no out_valid. A following LW at 0x0 with rdata=0x0000_0013 returns 0x13.
- Timeout with MEM_TIMEOUT=4 and memory_ready held 0 -> after 4 wait cycles ren drops and out_valid=1 with out_err=1.
